// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared widths and control-field bit positions for the ID/EX -> EX/MEM -> MEM/WB control chain.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pipe_ctrl_pkg;

  // Default field widths
  localparam int EX_W_DEF  = 3;   // ALUOp
  localparam int MEM_W_DEF = 3;   // {MemWrite, MemRead, xferByte}
  localparam int WB_W_DEF  = 2;   // {MemToReg, RegWrite}
  localparam int CNT_W_DEF = 16;  // performance counter width

  // Bit positions inside each field
  localparam int ALUOP_LSB    = 0;
  localparam int XFERBYTE_BIT = 0;
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 2;
  localparam int REGWRITE_BIT = 0;
  localparam int MEMTOREG_BIT = 1;

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Decode-side control inputs and per-stage gated control outputs of the control chain.
// Latency: none (wiring only); counter signals exist only when PIPE_CTRL_PERF_EN is defined.
// Backpressure: no handshake; freeze/bubble_id/flush_ex steer the chain.
interface pipe_ctrl_chain_if
  import pipe_ctrl_pkg::*;
#(
  parameter int EX_W  = EX_W_DEF,
  parameter int MEM_W = MEM_W_DEF,
  parameter int WB_W  = WB_W_DEF
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) ();

  // Decode slot and pipeline steering
  logic             id_valid;
  logic [EX_W-1:0]  id_ex_ctrl;
  logic [MEM_W-1:0] id_mem_ctrl;
  logic [WB_W-1:0]  id_wb_ctrl;
  logic             bubble_id;
  logic             flush_ex;
  logic             freeze;

  // Stage outputs, already gated by their valid bits
  logic             ex_valid;
  logic [EX_W-1:0]  ex_ctrl;
  logic [WB_W-1:0]  ex_wb_ctrl;
  logic             mem_valid;
  logic [MEM_W-1:0] mem_ctrl;
  logic [WB_W-1:0]  mem_wb_ctrl;
  logic             wb_valid;
  logic [WB_W-1:0]  wb_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, bubble_id, flush_ex, freeze,
    input  ex_valid, ex_ctrl, ex_wb_ctrl, mem_valid, mem_ctrl, mem_wb_ctrl, wb_valid, wb_ctrl,
    input  bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, bubble_id, flush_ex, freeze,
    output ex_valid, ex_ctrl, ex_wb_ctrl, mem_valid, mem_ctrl, mem_wb_ctrl, wb_valid, wb_ctrl,
    output bubble_cnt, flush_cnt
  );
`else
  modport master (
    output id_valid, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, bubble_id, flush_ex, freeze,
    input  ex_valid, ex_ctrl, ex_wb_ctrl, mem_valid, mem_ctrl, mem_wb_ctrl, wb_valid, wb_ctrl
  );

  modport slave (
    input  id_valid, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, bubble_id, flush_ex, freeze,
    output ex_valid, ex_ctrl, ex_wb_ctrl, mem_valid, mem_ctrl, mem_wb_ctrl, wb_valid, wb_ctrl
  );
`endif

endinterface

// File: rtl/pipe_ctrl_chain_stage_reg.sv
// One pipeline boundary register: W data bits plus a valid bit; kill empties the slot.
// Latency: one cycle from d_* to q_*.
// Backpressure: load=0 holds contents; kill wins over load and only clears valid.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         kill,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  // Kill leaves stale data behind; downstream gating by q_valid keeps it invisible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-field pipeline across ID/EX, EX/MEM, MEM/WB with bubble, flush and freeze (PIPE_CTRL_PERF_EN adds counters).
// Latency: one cycle per boundary; id_* reaches ex_* after 1 edge, mem_* after 2, wb_* after 3.
// Backpressure: freeze holds all three registers and defers any flush until the first unfrozen edge.
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int EX_W  = EX_W_DEF,
  parameter int MEM_W = MEM_W_DEF,
  parameter int WB_W  = WB_W_DEF
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic            clk,
  input  logic            reset,
  pipe_ctrl_chain_if.slave bus
);

  localparam int IDEX_W  = EX_W + MEM_W + WB_W;  // {ex, mem, wb}
  localparam int EXMEM_W = MEM_W + WB_W;         // {mem, wb}

  logic flush_pend;
  logic advance;
  logic flush;
  logic kill_idex;
  logic kill_exmem;

  // A flush requested while frozen and one arriving on the release edge merge into a single flush.
  assign advance    = !bus.freeze;
  assign flush      = bus.flush_ex | flush_pend;
  assign kill_idex  = advance & (flush | bus.bubble_id);
  assign kill_exmem = advance & flush;

  // Remember a flush seen during freeze; it is consumed by the first unfrozen edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flush_pend <= 1'b0;
    end else if (bus.freeze) begin
      flush_pend <= flush_pend | bus.flush_ex;
    end else begin
      flush_pend <= 1'b0;
    end
  end

  logic               idex_valid;
  logic [IDEX_W-1:0]  idex_data;
  logic               exmem_valid;
  logic [EXMEM_W-1:0] exmem_data;
  logic               memwb_valid;
  logic [WB_W-1:0]    memwb_data;

  pipe_stage_reg #(.W(IDEX_W)) u_id_ex (
    .clk     (clk),
    .reset   (reset),
    .load    (advance),
    .kill    (kill_idex),
    .d_valid (bus.id_valid),
    .d_data  ({bus.id_ex_ctrl, bus.id_mem_ctrl, bus.id_wb_ctrl}),
    .q_valid (idex_valid),
    .q_data  (idex_data)
  );

  // The EX field is dropped here; only {mem, wb} moves on.
  pipe_stage_reg #(.W(EXMEM_W)) u_ex_mem (
    .clk     (clk),
    .reset   (reset),
    .load    (advance),
    .kill    (kill_exmem),
    .d_valid (idex_valid),
    .d_data  (idex_data[EXMEM_W-1:0]),
    .q_valid (exmem_valid),
    .q_data  (exmem_data)
  );

  // The older instruction in MEM always completes, even across a flush.
  pipe_stage_reg #(.W(WB_W)) u_mem_wb (
    .clk     (clk),
    .reset   (reset),
    .load    (advance),
    .kill    (1'b0),
    .d_valid (exmem_valid),
    .d_data  (exmem_data[WB_W-1:0]),
    .q_valid (memwb_valid),
    .q_data  (memwb_data)
  );

  // Every control output is masked by its slot's valid so bubbles never assert MemWrite/MemRead/RegWrite.
  assign bus.ex_valid    = idex_valid;
  assign bus.ex_ctrl     = {EX_W{idex_valid}}  & idex_data[EXMEM_W + ALUOP_LSB +: EX_W];
  assign bus.ex_wb_ctrl  = {WB_W{idex_valid}}  & idex_data[WB_W-1:0];
  assign bus.mem_valid   = exmem_valid;
  assign bus.mem_ctrl    = {MEM_W{exmem_valid}} & exmem_data[EXMEM_W-1 -: MEM_W];
  assign bus.mem_wb_ctrl = {WB_W{exmem_valid}} & exmem_data[WB_W-1:0];
  assign bus.wb_valid    = memwb_valid;
  assign bus.wb_ctrl     = {WB_W{memwb_valid}} & memwb_data;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters; they only move on unfrozen edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (advance) begin
      if ((flush || bus.bubble_id) && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`endif

endmodule
